aes_encrypt_iter: RTL

//  Iterative AES-128 encryptor: one plaintext block per transaction, one round per clock, on-the-fly key expansion.

---
 rtl/aes_encrypt_iter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/aes_encrypt_iter.sv
// rtl/aes_encrypt_iter.sv - iterative AES-128 encryptor, one round per clock, on-the-fly key expansion
module aes_encrypt_iter #(
    parameter int         NR        = 10,
    parameter logic [7:0] RCON_INIT = 8'h01
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] iKey,
    input  logic [127:0] iPlaintext,
    input  logic         iValid,
    output logic         oReady,
    output logic [127:0] oCiphertext,
    output logic         oValid,
    input  logic         iReady,
    output logic         oBusy
);

    generate
        if (NR != 10) begin : g_bad_nr
            $error("aes_encrypt_iter: NR must be 10 (AES-128 only)");
        end
    endgenerate

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    state_t         r_fsm;
    state_t         w_fsm_next;
    logic [127:0]   r_data;
    logic [127:0]   r_rkey;
    logic [7:0]     r_rcon;
    logic [3:0]     r_round;
    logic [127:0]   r_ct;

    logic [7:0]     w_sr [16];
    logic [7:0]     w_mc [16];
    logic [127:0]   w_sr_flat;
    logic [127:0]   w_mc_flat;
    logic [31:0]    w_t;
    logic [31:0]    w_k0;
    logic [31:0]    w_k1;
    logic [31:0]    w_k2;
    logic [31:0]    w_k3;
    logic [127:0]   w_rkey_next;
    logic           w_last;
    logic [127:0]   w_round_out;

    // SubBytes fused with ShiftRows: row r of column c takes the byte from column (c+r) mod 4
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[4*c + r] = SBOX[r_data[127 - 8*(4*((c + r) % 4) + r) -: 8]];
            end
        end
    end

    // MixColumns on each column, then pack both candidate round results back into 128-bit words
    always_comb begin
        w_sr_flat = '0;
        w_mc_flat = '0;
        for (int c = 0; c < 4; c++) begin
            w_mc[4*c + 0] = xtime(w_sr[4*c]) ^ xtime(w_sr[4*c+1]) ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ w_sr[4*c+3];
            w_mc[4*c + 1] = w_sr[4*c] ^ xtime(w_sr[4*c+1]) ^ xtime(w_sr[4*c+2]) ^ w_sr[4*c+2] ^ w_sr[4*c+3];
            w_mc[4*c + 2] = w_sr[4*c] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2]) ^ xtime(w_sr[4*c+3]) ^ w_sr[4*c+3];
            w_mc[4*c + 3] = xtime(w_sr[4*c]) ^ w_sr[4*c] ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
        end
        for (int k = 0; k < 16; k++) begin
            w_sr_flat[127 - 8*k -: 8] = w_sr[k];
            w_mc_flat[127 - 8*k -: 8] = w_mc[k];
        end
    end

    // One key-schedule step producing the round key used by the current round
    always_comb begin
        w_t         = sub_word({r_rkey[23:0], r_rkey[31:24]}) ^ {r_rcon, 24'h0};
        w_k0        = r_rkey[127:96] ^ w_t;
        w_k1        = r_rkey[95:64]  ^ w_k0;
        w_k2        = r_rkey[63:32]  ^ w_k1;
        w_k3        = r_rkey[31:0]   ^ w_k2;
        w_rkey_next = {w_k0, w_k1, w_k2, w_k3};
        w_last      = (r_round == 4'(NR));
        w_round_out = (w_last ? w_sr_flat : w_mc_flat) ^ w_rkey_next;
    end

    // Next-state logic: accept in IDLE, iterate in ROUND, hold result in DONE until taken
    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            S_IDLE:  if (iValid) w_fsm_next = S_ROUND;
            S_ROUND: if (w_last) w_fsm_next = S_DONE;
            S_DONE:  if (iReady) w_fsm_next = S_IDLE;
            default: w_fsm_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm <= S_IDLE;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    // Datapath: load whitened block on accept, advance one round per edge, capture final ciphertext
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_rkey  <= '0;
            r_rcon  <= '0;
            r_round <= '0;
            r_ct    <= '0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (iValid) begin
                        r_data  <= iPlaintext ^ iKey;
                        r_rkey  <= iKey;
                        r_rcon  <= RCON_INIT;
                        r_round <= 4'd1;
                    end
                end
                S_ROUND: begin
                    r_data  <= w_round_out;
                    r_rkey  <= w_rkey_next;
                    r_rcon  <= xtime(r_rcon);
                    r_round <= r_round + 4'd1;
                    if (w_last) begin
                        r_ct <= w_round_out;
                    end
                end
                default: ;
            endcase
        end
    end

    assign oReady      = (r_fsm == S_IDLE);
    assign oBusy       = (r_fsm == S_ROUND);
    assign oValid      = (r_fsm == S_DONE);
    assign oCiphertext = r_ct;

endmodule
